// File: rtl/GLOBAL_PARAM.sv
// Shared widths for the PE accumulation datapath and a bit-width helper.
// RES_W is the accumulator width; DATA_W is the requantized output width.
package GLOBAL_PARAM;

    localparam int DATA_W = 8;
    localparam int TAIL_W = 8;
    localparam int RES_W  = DATA_W + TAIL_W;

    // Bits needed to index n items; never returns 0 so degenerate sizes still elaborate.
    function automatic int bw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/accum_drain_res_quant.sv
// One lane of requantization: round-half-up right shift, signed saturation to
// OUT_W bits, then optional ReLU. Purely combinational.
module res_quant
    import GLOBAL_PARAM::*;
#(
    parameter  int IN_W  = 16,
    parameter  int OUT_W = 8,
    localparam int SH_W  = bw(IN_W)
)(
    input  logic [IN_W-1:0]  i_x,
    input  logic [SH_W-1:0]  i_shift,
    input  logic             i_relu,
    output logic [OUT_W-1:0] o_y
);

    localparam logic signed [IN_W:0] SMAX = (IN_W+1)'((2**(OUT_W-1)) - 1);
    localparam logic signed [IN_W:0] SMIN = ~SMAX;

    logic signed [IN_W:0]    w_ext;
    logic signed [IN_W:0]    w_rnd;
    logic signed [IN_W:0]    w_sh;
    logic signed [OUT_W-1:0] w_sat;

    // One extra bit of headroom so adding the rounding constant never wraps.
    always_comb begin
        w_ext = {i_x[IN_W-1], i_x};
        w_rnd = '0;
        w_sh  = w_ext;
        if (i_shift != '0) begin
            w_rnd = (IN_W+1)'(1) << (i_shift - SH_W'(1));
            w_sh  = (w_ext + w_rnd) >>> i_shift;
        end
    end

    always_comb begin
        if (w_sh > SMAX)
            w_sat = SMAX[OUT_W-1:0];
        else if (w_sh < SMIN)
            w_sat = SMIN[OUT_W-1:0];
        else
            w_sat = w_sh[OUT_W-1:0];
    end

    assign o_y = (i_relu && w_sat[OUT_W-1]) ? '0 : w_sat;

endmodule

// File: rtl/accum_drain.sv
// Drains len rows of the accumulation buffer, requantizes every lane and streams
// rows out over valid/ready. Reads are throttled so the output FIFO never overflows.
module accum_drain
    import GLOBAL_PARAM::*;
#(
    parameter  int DEPTH  = 256,
    parameter  int BATCH  = 32,
    parameter  int RD_LAT = 1,
    parameter  int FIFO_D = RD_LAT + 2,
    localparam int ADDR_W = bw(DEPTH),
    localparam int SH_W   = bw(RES_W)
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W:0]         len,
    input  logic [SH_W-1:0]         shift,
    input  logic                    relu_en,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [BATCH*RES_W-1:0]  rd_data,
    output logic [BATCH*DATA_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
);

    localparam int PTR_W = bw(FIFO_D);
    localparam int CNT_W = bw(FIFO_D + 1);
    localparam int OCC_W = bw(FIFO_D + RD_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                           r_state;
    logic [ADDR_W:0]                  r_len;
    logic [ADDR_W:0]                  r_cnt;
    logic [SH_W-1:0]                  r_shift;
    logic                             r_relu;
    logic [ADDR_W-1:0]                r_addr;
    logic                             r_busy;
    logic                             r_done;
    logic [RD_LAT-1:0]                r_iss;
    logic [RD_LAT-1:0]                r_lst;
    logic [CNT_W-1:0]                 r_fcnt;
    logic [PTR_W-1:0]                 r_wp;
    logic [PTR_W-1:0]                 r_rp;
    logic [BATCH-1:0][DATA_W-1:0]     r_mem [FIFO_D];
    logic [FIFO_D-1:0]                r_mlast;

    logic [BATCH-1:0][DATA_W-1:0]     w_qrow;
    logic [OCC_W-1:0]                 w_inflt;
    logic [OCC_W-1:0]                 w_occ;
    logic [ADDR_W:0]                  w_cnt_nx;
    logic                             w_issue;
    logic                             w_last_rd;
    logic                             w_push;
    logic                             w_push_last;
    logic                             w_valid;
    logic                             w_head_last;
    logic                             w_pop;

    genvar g;
    generate
        for (g = 0; g < BATCH; g++) begin : g_lane
            res_quant #(.IN_W(RES_W), .OUT_W(DATA_W)) u_q (
                .i_x     (rd_data[g*RES_W +: RES_W]),
                .i_shift (r_shift),
                .i_relu  (r_relu),
                .o_y     (w_qrow[g])
            );
        end
    endgenerate

    always_comb begin
        w_inflt = '0;
        for (int i = 0; i < RD_LAT; i++)
            w_inflt = w_inflt + OCC_W'(r_iss[i]);
    end

    // Rows in flight plus rows buffered bound the FIFO fill once they all land.
    assign w_occ       = w_inflt + OCC_W'(r_fcnt);
    assign w_issue     = (r_state == S_RUN) && (w_occ < OCC_W'(FIFO_D));
    assign w_cnt_nx    = r_cnt + (ADDR_W+1)'(1);
    assign w_last_rd   = w_issue && (w_cnt_nx == r_len);
    assign w_push      = r_iss[RD_LAT-1];
    assign w_push_last = r_lst[RD_LAT-1];
    assign w_valid     = (r_fcnt != '0);
    assign w_head_last = r_mlast[r_rp];
    assign w_pop       = w_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_relu  <= 1'b0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len   <= len;
                        r_shift <= shift;
                        r_relu  <= relu_en;
                        r_cnt   <= '0;
                        if (len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_addr  <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_cnt <= w_cnt_nx;
                        // Address parks on the final row instead of wrapping.
                        if (w_last_rd)
                            r_state <= S_DRAIN;
                        else
                            r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_head_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iss  <= '0;
            r_lst  <= '0;
            r_wp   <= '0;
            r_rp   <= '0;
            r_fcnt <= '0;
        end else begin
            r_iss <= (r_iss << 1) | RD_LAT'(w_issue);
            r_lst <= (r_lst << 1) | RD_LAT'(w_last_rd);
            if (w_push)
                r_wp <= (r_wp == PTR_W'(FIFO_D - 1)) ? '0 : r_wp + PTR_W'(1);
            if (w_pop)
                r_rp <= (r_rp == PTR_W'(FIFO_D - 1)) ? '0 : r_rp + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + CNT_W'(1);
                2'b01:   r_fcnt <= r_fcnt - CNT_W'(1);
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp]   <= w_qrow;
            r_mlast[r_wp] <= w_push_last;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rd_addr   = r_addr;
    assign out_valid = w_valid;
    assign out_last  = w_valid && w_head_last;
    assign out_data  = w_valid ? r_mem[r_rp] : '0;

endmodule
